// File: rtl/game_pkg.sv
// Shared constants for the game timer: FSM state codes and the largest
// loadable second count.
package game_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_LOADED  = 3'd1;
   localparam state_t ST_RUNNING = 3'd2;
   localparam state_t ST_PAUSED  = 3'd3;
   localparam state_t ST_EXPIRED = 3'd4;

   localparam logic [6:0] MAX_SECS = 7'd99;

endpackage : game_pkg

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV counting cycles.
// The count only advances while run is high and is held otherwise, so a
// paused countdown resumes mid-second. clear wins over run.
module tick_prescaler #(
   parameter int TICK_DIV = 50_000_000   // must be >= 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int              CW     = $clog2(TICK_DIV);
   localparam logic [CW-1:0]   LAST_C = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count and wrap pulse; the pulse is suppressed by clear.
   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (run) begin
         if (cnt_q == LAST_C) begin
            cnt_d = '0;
            tick  = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Prescaler count register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : tick_prescaler

// File: rtl/game_timer.sv
// Round countdown timer. Loads a start value (clamped to 99 s) on reconfig,
// counts it down once per prescaler wrap while enabled, drives two BCD
// digits and holds a time-out flag once the count reaches 00.
module game_timer
   import game_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000   // clk cycles per second, >= 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Timer_enable,
   input  logic       Timer_reconfig,
   input  logic [6:0] Start_Secs,
   output logic [3:0] Secs_Tens,
   output logic [3:0] Secs_Ones,
   output logic       Tick,
   output logic       DigitTime_Out
);

   state_t     state_q, state_d;
   logic [3:0] tens_q,  tens_d;
   logic [3:0] ones_q,  ones_d;
   logic       tick_q,  tick_d;
   logic       tout_q,  tout_d;

   logic [6:0] clamp_s;
   logic [3:0] load_tens_s;
   logic [3:0] load_ones_s;
   logic       run_s;
   logic       wrap_s;
   logic       last_sec_s;

   // The prescaler only advances in RUNNING; a load restarts the second.
   assign run_s = (state_q == ST_RUNNING);

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .rst   (rst),
      .clear (Timer_reconfig),
      .run   (run_s),
      .tick  (wrap_s)
   );

   // Clamp the requested start value and split it into BCD digits.
   always_comb begin
      clamp_s     = 7'd0;
      load_tens_s = 4'd0;
      load_ones_s = 4'd0;
      if (Start_Secs > MAX_SECS) begin
         clamp_s = MAX_SECS;
      end else begin
         clamp_s = Start_Secs;
      end
      load_tens_s = 4'(clamp_s / 7'd10);
      load_ones_s = 4'(clamp_s - (7'(load_tens_s) * 7'd10));
   end

   // A decrement from 01 (or any value below it) lands on 00 and expires.
   assign last_sec_s = (tens_q == 4'd0) && (ones_q <= 4'd1);

   // Next-state logic: reconfig first, then per-state behaviour.
   always_comb begin
      state_d = state_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      tick_d  = 1'b0;
      tout_d  = tout_q;
      if (Timer_reconfig) begin
         tens_d = load_tens_s;
         ones_d = load_ones_s;
         if (clamp_s == 7'd0) begin
            tout_d  = 1'b1;
            state_d = ST_EXPIRED;
         end else begin
            tout_d  = 1'b0;
            state_d = ST_LOADED;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_LOADED: begin
               if (Timer_enable) begin
                  state_d = ST_RUNNING;
               end else begin
                  state_d = ST_LOADED;
               end
            end
            ST_RUNNING: begin
               if (Timer_enable) begin
                  state_d = ST_RUNNING;
               end else begin
                  state_d = ST_PAUSED;
               end
               if (wrap_s) begin
                  tick_d = 1'b1;
                  if (last_sec_s) begin
                     tens_d  = 4'd0;
                     ones_d  = 4'd0;
                     tout_d  = 1'b1;
                     state_d = ST_EXPIRED;
                  end else if (ones_q == 4'd0) begin
                     ones_d = 4'd9;
                     tens_d = tens_q - 4'd1;
                  end else begin
                     ones_d = ones_q - 4'd1;
                  end
               end else begin
                  tick_d = 1'b0;
               end
            end
            ST_PAUSED: begin
               if (Timer_enable) begin
                  state_d = ST_RUNNING;
               end else begin
                  state_d = ST_PAUSED;
               end
            end
            ST_EXPIRED: begin
               tens_d  = 4'd0;
               ones_d  = 4'd0;
               tout_d  = 1'b1;
               state_d = ST_EXPIRED;
            end
            default: begin
               state_d = ST_IDLE;
               tens_d  = 4'd0;
               ones_d  = 4'd0;
               tout_d  = 1'b0;
            end
         endcase
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
         tick_q  <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         tick_q  <= tick_d;
         tout_q  <= tout_d;
      end
   end

   assign Secs_Tens     = tens_q;
   assign Secs_Ones     = ones_q;
   assign Tick          = tick_q;
   assign DigitTime_Out = tout_q;

endmodule : game_timer

// File: doc/game_timer.md
# game_timer

Countdown timer that sits directly downstream of the game flow controller. It consumes that controller's `Timer_enable` and `Timer_reconfig` and returns `DigitTime_Out`, which ends the game round. It counts whole seconds down from a loaded start value, drives two BCD digits for the seven-segment time display, and raises a held time-out flag when the count reaches zero.

## Interface
- `TICK_DIV`, default 50_000_000: `clk` cycles per one-second tick. Must be ≥ 2.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `Timer_enable` input 1: level. High means count; low means hold.
- `Timer_reconfig` input 1: load request. Sampled every cycle.
- `Start_Secs` input 7: start value in binary, sampled only on reconfig.
- `Secs_Tens` output 4: BCD tens digit of remaining seconds.
- `Secs_Ones` output 4: BCD ones digit of remaining seconds.
- `Tick` output 1: one-cycle pulse on each decrement.
- `DigitTime_Out` output 1: time-out flag, held until the next reconfig.

## Operation
- States: IDLE, LOADED, RUNNING, PAUSED, EXPIRED.
- Reset values:
  - state IDLE.
  - `Secs_Tens` = 0, `Secs_Ones` = 0.
  - `Tick` = 0, `DigitTime_Out` = 0.
  - prescaler = 0.
- `Timer_reconfig` = 1 has priority over everything else, in every state:
  - clamp `Start_Secs` to 99;
  - convert to BCD and load the digits;
  - clear the prescaler and `DigitTime_Out`;
  - go to LOADED, or to EXPIRED with `DigitTime_Out` = 1 if the clamped value is 0.
- IDLE: ignores `Timer_enable`. Leaves only on reconfig.
- LOADED: goes to RUNNING on `Timer_enable` = 1.
- RUNNING:
  - Prescaler increments each cycle and wraps at `TICK_DIV`-1 → 0.
  - On each wrap, `Tick` pulses and the count decrements by one in BCD. Ones 0 borrows: ones → 9, tens − 1.
  - `Timer_enable` = 0 → PAUSED. The prescaler keeps its value.
- PAUSED: goes back to RUNNING on `Timer_enable` = 1 and resumes from the held prescaler value.
- Expiry: a wrap while the count is 01 gives:
  - count 00;
  - `DigitTime_Out` = 1 at the same edge;
  - state EXPIRED.
- EXPIRED:
  - count frozen at 00, no further `Tick`;
  - `DigitTime_Out` stays 1 regardless of `Timer_enable`;
  - leaves only on reconfig.
- The count never underflows below 00.

## Timing
- All outputs are registered. Nothing is combinational from inputs to outputs.
- Reconfig edge N: digits valid and `DigitTime_Out` = 0 after edge N.
- First decrement: `TICK_DIV` cycles after the first cycle in which RUNNING is entered.
- A decrement and `Tick` occur on the same edge. `Tick` is high for exactly one cycle.
- Reconfig and enable both high in one cycle: the load wins and the state is LOADED, not RUNNING. Counting starts the following cycle if enable is still high.
- Reconfig in the same cycle as a prescaler wrap: the load wins, with no decrement and no `Tick`.
- Enable falling in the same cycle as a wrap: the decrement still happens, then the state is PAUSED.
- The controller samples `DigitTime_Out` one or more cycles after expiry. Holding the flag as a level guarantees it is seen.
- Reset asserted mid-count: all outputs go to reset values immediately, with no clock required.

## Structure
- Shared package `game_pkg`:
  - state encoding constants: IDLE=0, LOADED=1, RUNNING=2, PAUSED=3, EXPIRED=4, width 3;
  - `MAX_SECS` = 99.
- Sub-module `tick_prescaler`:
  - ports: `clk`, `rst`, `clear`, `run`, `tick`;
  - counter width is $clog2(`TICK_DIV`);
  - `clear` has priority over `run`.
- Binary-to-BCD of the clamped 7-bit value is combinational inside `game_timer`: tens = value/10, ones = value − 10·tens.

## Test plan
All scenarios use `TICK_DIV` = 4.
- Reset then idle: `rst` low then high, no reconfig, `Timer_enable` = 1 for 20 cycles → digits 0/0, `Tick` never high, `DigitTime_Out` = 0, state IDLE.
- Load and count: reconfig with `Start_Secs` = 12, then enable → digits 1/2, after 4 cycles 1/1, after 8 cycles 1/0, after 12 cycles 0/9 (borrow). One `Tick` per 4 cycles.
- Expiry: `Start_Secs` = 2, enable held → `DigitTime_Out` rises exactly 8 cycles after the first RUNNING cycle, with digits 0/0. It stays high for 20 more cycles and no further `Tick` occurs.
- Pause/resume: `Start_Secs` = 5, enable for 6 cycles, low for 10, then high → digits frozen at 0/4 while low. The next decrement to 0/3 occurs 2 cycles after resume.
- Clamp and zero: `Start_Secs` = 120 → digits 9/9. `Start_Secs` = 0 → `DigitTime_Out` = 1 after the load edge, and the state is EXPIRED.
- Priority/reset:
  - reconfig coincident with a wrap → reloaded value, no `Tick`;
  - reconfig in EXPIRED → `DigitTime_Out` clears;
  - async `rst` low mid-count → outputs zero before the next clock edge.
